param_updown_counter: RTL and testbench
=======================================

# param_updown_counter

Parametrised up/down counter, the general-purpose successor to the fixed 4-bit saturating down counter. It supports configurable width, reset value, and clock prescaling. Boundary behaviour is selectable at run time: saturate, wrap, or auto-reload. It also provides parallel load and a terminal-count pulse. It sits in timer, delay and event-counting paths, wherever the design needs a programmable tick count.

## Interface
Parameters:
- WIDTH, 4: counter width in bits (≥1).
- RESET_VAL, {WIDTH{1'b1}}: value of count and of the reload register after reset.
- PRESCALE, 1: a step occurs on every PRESCALE-th enabled cycle (≥1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable; feeds the prescaler.
- dir  in  1  direction: 0 = down, 1 = up.
- mode  in  2  boundary mode: 00 saturate, 01 wrap, 10 auto-reload, 11 reserved (behaves as saturate).
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value for load; also captured into the reload register.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle.
- zero  out  1  count == 0, combinational from count.
- at_max  out  1  count == 2^WIDTH-1, combinational from count.

## Operation
- Priority per cycle: rst > load > step.
- Reset values:
  - count = RESET_VAL; reload register = RESET_VAL.
  - tc = 0; prescaler phase = 0.
- Load:
  - count ← load_val; reload register ← load_val.
  - Prescaler phase clears to 0; tc = 0 next cycle.
  - A step coinciding with a load is discarded.
- Step generation: in each cycle with en=1, the prescaler phase increments.
  - A step fires when the phase equals PRESCALE-1, and the phase then wraps to 0.
  - With PRESCALE=1, step = en.
  - With en=0 the phase holds.
- Normal step: count ± 1 per dir.
- Boundary: the boundary is a step down with count==0, or a step up with count==max. At the boundary:
  - saturate: count holds.
  - wrap: count goes to max (down) or 0 (up).
  - auto-reload: count ← reload register, in either direction.
- tc: set to 1 for exactly the cycle after every boundary step, in all modes. This includes each repeated attempt while saturated. Otherwise tc = 0.
- Mid-operation changes:
  - Changing dir or mode affects only subsequent steps.
  - The prescaler phase is unaffected by dir or mode.
- Reset asserted mid-count overrides load and step in the same cycle.

## Timing
- Step latency is 1 cycle: count reflects a step or load on the edge ending the cycle in which it occurred.
- tc is registered and aligned with the post-boundary count value.
- zero and at_max are combinational from count, so they carry no extra latency.
- Throughput is one step per PRESCALE enabled cycles; there is no backpressure or handshake.

## Structure
- Shared package counter_pkg holds:
  - mode encodings: MODE_SAT=2'b00, MODE_WRAP=2'b01, MODE_RELOAD=2'b10.
  - direction constants: DIR_DOWN=0, DIR_UP=1.
- Sub-module tick_prescaler (parameter PRESCALE; ports clk, rst, en, clr, tick):
  - internal phase width is max(1, $clog2(PRESCALE)).
  - clr is driven by load.
- The top level contains the reload register, the boundary/next-value logic and the tc register.

## Test plan
All scenarios use WIDTH=4 unless noted.
- Reset and saturate down, PRESCALE=1: rst 1 cycle → count=15, tc=0. Then en=1, dir=0, mode=00 for 17 cycles → count 14…0, then holds 0. tc pulses on cycles 16 and 17; zero=1 from count=0.
- Wrap up: load 14, dir=1, mode=01, en=1 → count 15, 0, 1. tc=1 only with count=0; at_max=1 only with count=15.
- Auto-reload: load 3, dir=0, mode=10, en=1 → count 2, 1, 0, 3, 2…. tc=1 with each reload to 3.
- Prescaler, PRESCALE=3: load 5, dir=0, en=1 → count changes every 3rd cycle (4, 3…). Dropping en for 2 cycles freezes the phase; the next step occurs after the remaining enabled cycles.
- Simultaneous events:
  - load 9 in the same cycle as a step → count=9, no decrement, prescaler phase restarts.
  - rst in the same cycle as load → count=15.
- Mid-operation changes: switch dir from 0 to 1 at count=4 → next step gives 5. Switch mode from 01 to 00 at count=0 (down) → count holds 0, tc still pulses.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the parametrised up/down counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_SAT    = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_RELOAD = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits one tick on every PRESCALE-th enabled cycle.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_phase;

  assign tick = en && (r_phase == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_phase <= '0;
    end else if (en) begin
      if (r_phase == LAST) r_phase <= '0;
      else                 r_phase <= r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with saturate/wrap/auto-reload boundaries,
// parallel load, prescaled stepping and a registered terminal-count pulse.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b1}},
  parameter int unsigned       PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero,
  output logic             at_max
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             w_step;
  logic             w_boundary;
  logic [WIDTH-1:0] w_next;
  logic             w_tc_next;
  dir_e             w_dir;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .tick(w_step)
  );

  assign w_dir      = dir_e'(dir);
  assign w_boundary = (w_dir == DIR_DOWN) ? (r_count == '0) : (r_count == '1);

  always_comb begin
    w_next    = r_count;
    w_tc_next = 1'b0;
    if (w_step) begin
      if (w_boundary) begin
        w_tc_next = 1'b1;
        case (mode_e'(mode))
          MODE_WRAP:   w_next = (w_dir == DIR_UP) ? '0 : '1;
          MODE_RELOAD: w_next = r_reload;
          default:     w_next = r_count;
        endcase
      end else if (w_dir == DIR_UP) begin
        w_next = r_count + 1'b1;
      end else begin
        w_next = r_count - 1'b1;
      end
    end
  end

  // Load wins over a coincident step; the prescaler is cleared by load as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= RESET_VAL;
      r_reload <= RESET_VAL;
      r_tc     <= 1'b0;
    end else if (load) begin
      r_count  <= load_val;
      r_reload <= load_val;
      r_tc     <= 1'b0;
    end else begin
      r_count  <= w_next;
      r_tc     <= w_tc_next;
    end
  end

  assign count  = r_count;
  assign tc     = r_tc;
  assign zero   = (r_count == '0);
  assign at_max = (r_count == '1);

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: one PRESCALE=1 and one PRESCALE=3 instance
// driven in parallel and compared against a behavioural model.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] cnt_o [2];
  logic       tc_o  [2];
  logic       zero_o[2];
  logic       max_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  // model state, index 0: PRESCALE=1, index 1: PRESCALE=3
  int m_cnt[2];
  int m_rel[2];
  int m_en_seen[2];
  int m_tc[2];
  int ps[2] = '{1, 3};

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .RESET_VAL(4'hF), .PRESCALE(1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .count(cnt_o[0]), .tc(tc_o[0]), .zero(zero_o[0]),
    .at_max(max_o[0])
  );

  param_updown_counter #(.WIDTH(4), .RESET_VAL(4'hF), .PRESCALE(3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .count(cnt_o[1]), .tc(tc_o[1]), .zero(zero_o[1]),
    .at_max(max_o[1])
  );

  // Advance one clock and apply the counter rules to the model.
  task automatic clk_step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cnt[k] = 15; m_rel[k] = 15; m_tc[k] = 0; m_en_seen[k] = 0;
      end else if (load) begin
        m_cnt[k] = int'(load_val); m_rel[k] = int'(load_val);
        m_tc[k] = 0; m_en_seen[k] = 0;
      end else begin
        bit fire = 1'b0;
        m_tc[k] = 0;
        if (en) begin
          m_en_seen[k]++;
          if (m_en_seen[k] == ps[k]) begin fire = 1'b1; m_en_seen[k] = 0; end
        end
        if (fire) begin
          if ((dir && m_cnt[k] == 15) || (!dir && m_cnt[k] == 0)) begin
            m_tc[k] = 1;
            if (mode == 2'b01)      m_cnt[k] = dir ? 0 : 15;
            else if (mode == 2'b10) m_cnt[k] = m_rel[k];
          end else begin
            m_cnt[k] = dir ? m_cnt[k] + 1 : m_cnt[k] - 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; en = 1'b0;
    clk_step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (cnt_o[k] !== 4'd15 || tc_o[k] !== 1'b0 || zero_o[k] !== 1'b0 || max_o[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset[%0d]: count=%0d tc=%b zero=%b at_max=%b, need 15 0 0 1",
                 k, cnt_o[k], tc_o[k], zero_o[k], max_o[k]);
      end
    end
  endtask

  task automatic test_saturate_down();
    en = 1'b1; dir = 1'b0; mode = 2'b00;
    for (int i = 1; i <= 17; i++) begin
      int exp_c = (i <= 15) ? 15 - i : 0;
      clk_step();
      n_tests++;
      if (cnt_o[0] !== 4'(exp_c) || tc_o[0] !== (i >= 16) || zero_o[0] !== (exp_c == 0)) begin
        n_fail++;
        $display("FAIL sat_down cyc%0d: count=%0d tc=%b zero=%b, need %0d %b %b",
                 i, cnt_o[0], tc_o[0], zero_o[0], exp_c, i >= 16, exp_c == 0);
      end
      n_tests++;
      if (cnt_o[1] !== 4'(m_cnt[1]) || tc_o[1] !== m_tc[1][0]) begin
        n_fail++;
        $display("FAIL sat_down_ps3 cyc%0d: count=%0d tc=%b, need %0d %0d",
                 i, cnt_o[1], tc_o[1], m_cnt[1], m_tc[1]);
      end
    end
  endtask

  task automatic test_wrap_up();
    int exp_c[3] = '{15, 0, 1};
    load = 1'b1; load_val = 4'd14; en = 1'b0;
    clk_step();
    load = 1'b0; dir = 1'b1; mode = 2'b01; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      n_tests++;
      if (cnt_o[0] !== 4'(exp_c[i]) || tc_o[0] !== (exp_c[i] == 0) || max_o[0] !== (exp_c[i] == 15)) begin
        n_fail++;
        $display("FAIL wrap_up step%0d: count=%0d tc=%b at_max=%b, need %0d %b %b",
                 i, cnt_o[0], tc_o[0], max_o[0], exp_c[i], exp_c[i] == 0, exp_c[i] == 15);
      end
    end
  endtask

  task automatic test_reload();
    int exp_c[6] = '{2, 1, 0, 3, 2, 1};
    load = 1'b1; load_val = 4'd3; en = 1'b0;
    clk_step();
    load = 1'b0; dir = 1'b0; mode = 2'b10; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clk_step();
      n_tests++;
      if (cnt_o[0] !== 4'(exp_c[i]) || tc_o[0] !== (i == 3)) begin
        n_fail++;
        $display("FAIL reload step%0d: count=%0d tc=%b, need %0d %b",
                 i, cnt_o[0], tc_o[0], exp_c[i], i == 3);
      end
    end
  endtask

  task automatic test_prescale();
    // en pattern after load: 6 on, 1 on, 2 off, 2 on
    bit en_pat[11]  = '{1,1,1,1,1,1,1,0,0,1,1};
    int exp_c[11]   = '{5,5,4,4,4,3,3,3,3,3,2};
    load = 1'b1; load_val = 4'd5; en = 1'b0; mode = 2'b00;
    clk_step();
    load = 1'b0; dir = 1'b0;
    for (int i = 0; i < 11; i++) begin
      en = en_pat[i];
      clk_step();
      n_tests++;
      if (cnt_o[1] !== 4'(exp_c[i])) begin
        n_fail++;
        $display("FAIL prescale cyc%0d: count=%0d, need %0d", i, cnt_o[1], exp_c[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    int exp1[3] = '{9, 9, 8};
    dir = 1'b0; mode = 2'b00; en = 1'b1;
    load = 1'b1; load_val = 4'd9;
    clk_step();
    load = 1'b0;
    n_tests++;
    if (cnt_o[0] !== 4'd9 || cnt_o[1] !== 4'd9 || tc_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL load_vs_step: count0=%0d count1=%0d tc0=%b, need 9 9 0",
               cnt_o[0], cnt_o[1], tc_o[0]);
    end
    for (int i = 0; i < 3; i++) begin
      clk_step();
      n_tests++;
      if (cnt_o[1] !== 4'(exp1[i]) || cnt_o[0] !== 4'(8 - i)) begin
        n_fail++;
        $display("FAIL phase_restart cyc%0d: count0=%0d count1=%0d, need %0d %0d",
                 i, cnt_o[0], cnt_o[1], 8 - i, exp1[i]);
      end
    end
    rst = 1'b1; load = 1'b1; load_val = 4'd2;
    clk_step();
    rst = 1'b0; load = 1'b0;
    n_tests++;
    if (cnt_o[0] !== 4'd15 || cnt_o[1] !== 4'd15) begin
      n_fail++;
      $display("FAIL rst_vs_load: count0=%0d count1=%0d, need 15 15", cnt_o[0], cnt_o[1]);
    end
  endtask

  task automatic test_mid_change();
    load = 1'b1; load_val = 4'd6; en = 1'b0; dir = 1'b0; mode = 2'b00;
    clk_step();
    load = 1'b0; en = 1'b1;
    clk_step(); clk_step();
    dir = 1'b1;
    clk_step();
    n_tests++;
    if (cnt_o[0] !== 4'd5) begin
      n_fail++;
      $display("FAIL dir_change: count=%0d, need 5", cnt_o[0]);
    end
    load = 1'b1; load_val = 4'd1; dir = 1'b0; mode = 2'b01;
    clk_step();
    load = 1'b0;
    clk_step();
    mode = 2'b00;
    clk_step();
    n_tests++;
    if (cnt_o[0] !== 4'd0 || tc_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_change: count=%0d tc=%b, need 0 1", cnt_o[0], tc_o[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 4'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom);
      mode     = 2'($urandom);
      clk_step();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (cnt_o[k] !== 4'(m_cnt[k]) || tc_o[k] !== m_tc[k][0] ||
            zero_o[k] !== (m_cnt[k] == 0) || max_o[k] !== (m_cnt[k] == 15)) begin
          n_fail++;
          $display("FAIL random[%0d] cyc%0d: count=%0d tc=%b zero=%b at_max=%b, need %0d %0d %b %b",
                   k, i, cnt_o[k], tc_o[k], zero_o[k], max_o[k],
                   m_cnt[k], m_tc[k], m_cnt[k] == 0, m_cnt[k] == 15);
        end
      end
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_saturate_down();
    test_wrap_up();
    test_reload();
    test_prescale();
    test_simultaneous();
    test_mid_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
